// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline register chain: default sizes,
// counter type and the per-stage slicing helper for flattened stage buses.
package cpu_pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32'd32;
  localparam int unsigned DEF_STAGES = 32'd4;
  localparam int unsigned DEF_CNT_W  = 32'd32;

  typedef logic [DEF_CNT_W-1:0] perf_cnt_t;

  // Bit offset of stage idx inside a flattened STAGES*width bus
  function automatic int unsigned stage_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid flag plus payload register, with move/load/flush
// controls supplied by the chain controller.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32'd32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              move,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;

  // Valid flag: flush wins, a moving stage takes the incoming valid, else hold
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (move) begin
      valid_r <= load;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload: only a real incoming item overwrites it; bubbles leave it alone
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_r <= {DATA_W{1'b0}};
    end else if (move && load && !flush) begin
      data_r <= load_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/pipe_chain_ctrl.sv
// Pipeline register chain with per-stage stall, younger-stage flush and
// ready/valid ends. Optional counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_chain_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall_req,
  input  logic [STAGES-1:0]        flush_req,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  input  logic                     perf_clr,
  output logic [CNT_W-1:0]         perf_retired,
  output logic [CNT_W-1:0]         perf_stall,
  output logic [CNT_W-1:0]         perf_flush
);

  logic [STAGES-1:0] move_s;
  logic [STAGES-1:0] inv_s;
  logic [STAGES-1:0] flush_mask_s;
  logic [STAGES-1:0] valid_s;
  logic [DATA_W-1:0] din_s  [STAGES];
  logic [DATA_W-1:0] data_s [STAGES];
  logic              any_flush_s;
  logic              in_ready_s;
  logic              chain_s;
  logic              flush_acc_s;

  // Move chain from the oldest stage down, plus the flush mask of younger stages
  always_comb begin
    chain_s      = out_ready;
    flush_acc_s  = 1'b0;
    move_s       = {STAGES{1'b0}};
    flush_mask_s = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      move_s[i]       = enable & ~stall_req[i] & (~valid_s[i] | chain_s);
      chain_s         = move_s[i];
      flush_acc_s     = flush_acc_s | flush_req[i];
      flush_mask_s[i] = flush_acc_s & enable;
    end
    any_flush_s = |flush_req;
    in_ready_s  = move_s[0] & ~any_flush_s;
  end

  // Incoming item for each stage: producer for stage 0, the older neighbour otherwise
  always_comb begin
    inv_s = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      din_s[i] = {DATA_W{1'b0}};
    end
    inv_s[0] = in_valid & in_ready_s;
    din_s[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      inv_s[i] = valid_s[i-1] & ~stall_req[i-1];
      din_s[i] = data_s[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage_reg #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk       (clk),
      .arst_n    (arst_n),
      .move      (move_s[g]),
      .load      (inv_s[g]),
      .flush     (flush_mask_s[g]),
      .load_data (din_s[g]),
      .valid     (valid_s[g]),
      .data      (data_s[g])
    );
    assign stage_data[stage_lsb(g, DATA_W) +: DATA_W] = data_s[g];
  end

  assign in_ready    = in_ready_s;
  assign stage_valid = valid_s;
  assign out_valid   = valid_s[STAGES-1];
  assign out_data    = data_s[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             retire_s;
  logic [CNT_W-1:0] retired_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  assign retire_s = valid_s[STAGES-1] & out_ready & enable;

  // Saturating event counters; clear beats increment, everything frozen while disabled
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      retired_r   <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (!enable) begin
      retired_r   <= retired_r;
      stall_cnt_r <= stall_cnt_r;
      flush_cnt_r <= flush_cnt_r;
    end else if (perf_clr) begin
      retired_r   <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (retire_s && (retired_r != CNT_MAX)) retired_r <= retired_r + CNT_ONE;
      else retired_r <= retired_r;
      if ((|stall_req) && (stall_cnt_r != CNT_MAX)) stall_cnt_r <= stall_cnt_r + CNT_ONE;
      else stall_cnt_r <= stall_cnt_r;
      if ((|flush_req) && (flush_cnt_r != CNT_MAX)) flush_cnt_r <= flush_cnt_r + CNT_ONE;
      else flush_cnt_r <= flush_cnt_r;
    end
  end

  assign perf_retired = retired_r;
  assign perf_stall   = stall_cnt_r;
  assign perf_flush   = flush_cnt_r;
`else
  logic unused_perf_clr_s;

  assign unused_perf_clr_s = perf_clr;
  assign perf_retired      = {CNT_W{1'b0}};
  assign perf_stall        = {CNT_W{1'b0}};
  assign perf_flush        = {CNT_W{1'b0}};
`endif

endmodule
